delta_spike_decoder: RTL and testbench

Downstream consumer of the delta-modulation spike stage. Rebuilds a staircase approximation of the original sample stream by integrating up/down spikes by a programmable step, with saturation. Also counts up/down spikes over fixed windows and hands each window's totals to a host-side reader through a valid/ready handshake. Intended to close the loop in-chip, so encoder fidelity can be checked on the same die.

---
 rtl/delta_spike_decoder_pkg.sv | 27 ++
 rtl/spike_window_counter.sv | 72 +++++++
 rtl/delta_spike_decoder.sv | 86 ++++++++
 tb/tb_delta_spike_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_spike_decoder_pkg.sv
// Shared definitions for the delta-modulation spike path: the spike bus encoding
// used by both encoder and decoder, and a saturating step helper.
package delta_spike_decoder_pkg;

    localparam logic [1:0] SPIKE_NONE = 2'b00;
    localparam logic [1:0] SPIKE_UP   = 2'b01;
    localparam logic [1:0] SPIKE_DOWN = 2'b10;
    localparam logic [1:0] SPIKE_BOTH = 2'b11;

    // Operands are widened to 32 bits so one helper serves any DATA_W up to 32;
    // the extra carry bit catches overflow before clamping to 2^width-1.
    function automatic logic [31:0] sat_step(input logic [31:0] value,
                                             input logic [31:0] step,
                                             input logic        up,
                                             input int unsigned width);
        logic [32:0] max_val;
        logic [32:0] sum;
        max_val = (33'd1 << width) - 33'd1;
        sum     = {1'b0, value} + {1'b0, step};
        if (up) begin
            sat_step = (sum > max_val) ? max_val[31:0] : sum[31:0];
        end else begin
            sat_step = (step > value) ? 32'd0 : (value - step);
        end
    endfunction

endpackage

// File: rtl/spike_window_counter.sv
// Counts up/down spikes over fixed windows of enabled cycles and offers each
// window's totals to a reader via valid/ready, reporting dropped results.
module spike_window_counter
    import delta_spike_decoder_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       spike_in,
    input  logic             win_ready,
    output logic [CNT_W-1:0] win_up,
    output logic [CNT_W-1:0] win_down,
    output logic             win_valid,
    output logic             overrun_event
);

    localparam int CYC_W = $clog2(WINDOW);

    logic [CYC_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] work_up;
    logic [CNT_W-1:0] work_down;
    logic [CNT_W-1:0] final_up;
    logic [CNT_W-1:0] final_down;
    logic             done;
    logic             xfer;

    // Final counts include the completing cycle's own spike so nothing is lost at the boundary.
    always_comb begin
        done          = en && (cycle_cnt == CYC_W'(WINDOW - 1));
        xfer          = win_valid && win_ready;
        final_up      = work_up   + CNT_W'(en && (spike_in == SPIKE_UP));
        final_down    = work_down + CNT_W'(en && (spike_in == SPIKE_DOWN));
        overrun_event = done && win_valid && !win_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            work_up   <= '0;
            work_down <= '0;
        end else if (en) begin
            if (done) begin
                cycle_cnt <= '0;
                work_up   <= '0;
                work_down <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + CYC_W'(1);
                work_up   <= final_up;
                work_down <= final_down;
            end
        end
    end

    // A pending result is never overwritten; a completion only lands if the slot is free or freeing now.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_up    <= '0;
            win_down  <= '0;
        end else if (done && (!win_valid || xfer)) begin
            win_valid <= 1'b1;
            win_up    <= final_up;
            win_down  <= final_down;
        end else if (xfer) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/delta_spike_decoder.sv
// Rebuilds a saturating staircase from encoder spikes and tracks sticky error
// flags; per-window spike statistics come from spike_window_counter.
module delta_spike_decoder
    import delta_spike_decoder_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        spike_in,
    input  logic [DATA_W-1:0] step,
    input  logic              init_load,
    input  logic [DATA_W-1:0] init_value,
    input  logic              clear_flags,
    output logic [DATA_W-1:0] recon_out,
    output logic [CNT_W-1:0]  win_up,
    output logic [CNT_W-1:0]  win_down,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              conflict,
    output logic              overrun
);

    logic [DATA_W-1:0] recon_next;
    logic              conflict_set;
    logic              overrun_event;

    spike_window_counter #(
        .WINDOW(WINDOW),
        .CNT_W (CNT_W)
    ) u_window (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .spike_in     (spike_in),
        .win_ready    (win_ready),
        .win_up       (win_up),
        .win_down     (win_down),
        .win_valid    (win_valid),
        .overrun_event(overrun_event)
    );

    // Preload beats any spike; a contradictory 11 spike leaves the sample where it was.
    always_comb begin
        recon_next = recon_out;
        if (init_load) begin
            recon_next = init_value;
        end else if (spike_in == SPIKE_UP) begin
            recon_next = DATA_W'(sat_step(32'(recon_out), 32'(step), 1'b1, DATA_W));
        end else if (spike_in == SPIKE_DOWN) begin
            recon_next = DATA_W'(sat_step(32'(recon_out), 32'(step), 1'b0, DATA_W));
        end
        conflict_set = en && (spike_in == SPIKE_BOTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            recon_out <= '0;
        end else if (en) begin
            recon_out <= recon_next;
        end
    end

    // Setting outranks clearing so an event coinciding with clear_flags is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (conflict_set) begin
                conflict <= 1'b1;
            end else if (clear_flags) begin
                conflict <= 1'b0;
            end
            if (overrun_event) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_delta_spike_decoder.sv
// Self-checking bench: directed scenarios with literal expectations plus a long
// randomized run compared every cycle against an integer/queue reference model.
module tb_delta_spike_decoder;

    localparam int DATA_W = 4;
    localparam int WINDOW = 16;
    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int MAXV   = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [1:0]        spike_in;
    logic [DATA_W-1:0] step;
    logic              init_load;
    logic [DATA_W-1:0] init_value;
    logic              clear_flags;
    logic              win_ready;
    logic [DATA_W-1:0] recon_out;
    logic [CNT_W-1:0]  win_up;
    logic [CNT_W-1:0]  win_down;
    logic              win_valid;
    logic              conflict;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delta_spike_decoder #(.DATA_W(DATA_W), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .spike_in   (spike_in),
        .step       (step),
        .init_load  (init_load),
        .init_value (init_value),
        .clear_flags(clear_flags),
        .recon_out  (recon_out),
        .win_up     (win_up),
        .win_down   (win_down),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .conflict   (conflict),
        .overrun    (overrun)
    );

    // Reference model: enabled cycles since reset define window boundaries; the
    // current window's spikes are kept in a queue and tallied at completion.
    int m_recon, m_enabled, m_snap_up, m_snap_down;
    bit m_valid, m_conflict, m_overrun, model_live;
    int win_spikes[$];

    always @(posedge clk) begin
        if (reset) begin
            m_recon = 0; m_enabled = 0; m_snap_up = 0; m_snap_down = 0;
            m_valid = 0; m_conflict = 0; m_overrun = 0;
            win_spikes.delete();
            model_live = 1;
        end else begin
            bit xfer, complete, c_set, o_set;
            int nu, nd;
            xfer = m_valid && win_ready;
            complete = 0; c_set = 0; o_set = 0;
            if (en) begin
                win_spikes.push_back(int'(spike_in));
                m_enabled++;
                complete = (m_enabled % WINDOW) == 0;
                c_set = (spike_in == 2'b11);
                if (init_load) m_recon = int'(init_value);
                else if (spike_in == 2'b01)
                    m_recon = (m_recon + int'(step) > MAXV) ? MAXV : m_recon + int'(step);
                else if (spike_in == 2'b10)
                    m_recon = (m_recon - int'(step) < 0) ? 0 : m_recon - int'(step);
            end
            if (complete) begin
                nu = 0; nd = 0;
                foreach (win_spikes[k]) begin
                    if (win_spikes[k] == 1) nu++;
                    if (win_spikes[k] == 2) nd++;
                end
                win_spikes.delete();
                if (!m_valid || xfer) begin
                    m_snap_up = nu; m_snap_down = nd; m_valid = 1;
                end else begin
                    o_set = 1;
                end
            end else if (xfer) begin
                m_valid = 0;
            end
            if (c_set) m_conflict = 1; else if (clear_flags) m_conflict = 0;
            if (o_set) m_overrun = 1;  else if (clear_flags) m_overrun = 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (model_live) begin
            checkOutput("model recon_out", int'(recon_out), m_recon);
            checkOutput("model win_valid", int'(win_valid), int'(m_valid));
            checkOutput("model win_up", int'(win_up), m_snap_up);
            checkOutput("model win_down", int'(win_down), m_snap_down);
            checkOutput("model conflict", int'(conflict), int'(m_conflict));
            checkOutput("model overrun", int'(overrun), int'(m_overrun));
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] s,
                                 input logic [DATA_W-1:0] st, input logic il,
                                 input logic [DATA_W-1:0] iv, input logic cf,
                                 input logic rdy);
        @(negedge clk);
        reset = r; en = e; spike_in = s; step = st; init_load = il;
        init_value = iv; clear_flags = cf; win_ready = rdy;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " recon"}, int'(recon_out), 0);
        checkOutput({tag, " valid"}, int'(win_valid), 0);
        checkOutput({tag, " up"}, int'(win_up), 0);
        checkOutput({tag, " down"}, int'(win_down), 0);
        checkOutput({tag, " conflict"}, int'(conflict), 0);
        checkOutput({tag, " overrun"}, int'(overrun), 0);
    endtask

    initial begin
        logic [1:0] sp;
        reset = 1; en = 0; spike_in = 0; step = 0; init_load = 0;
        init_value = 0; clear_flags = 0; win_ready = 0;
        $display("[TB] start");

        applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0);
        settle();
        checkAllZero("reset");

        // Staircase: 5, 8, 11, 8
        applyStimulus(0, 1, 2'b00, 3, 1, 5, 0, 1); settle(); checkOutput("init 5", int'(recon_out), 5);
        applyStimulus(0, 1, 2'b01, 3, 0, 0, 0, 1); settle(); checkOutput("up to 8", int'(recon_out), 8);
        applyStimulus(0, 1, 2'b01, 3, 0, 0, 0, 1); settle(); checkOutput("up to 11", int'(recon_out), 11);
        applyStimulus(0, 1, 2'b10, 3, 0, 0, 0, 1); settle(); checkOutput("down to 8", int'(recon_out), 8);

        // Saturation at both rails and zero step
        applyStimulus(0, 1, 2'b00, 3, 1, 14, 0, 1);
        applyStimulus(0, 1, 2'b01, 3, 0, 0, 0, 1); settle(); checkOutput("sat high", int'(recon_out), 15);
        applyStimulus(0, 1, 2'b00, 3, 1, 2, 0, 1);
        applyStimulus(0, 1, 2'b10, 3, 0, 0, 0, 1); settle(); checkOutput("sat low", int'(recon_out), 0);
        applyStimulus(0, 1, 2'b00, 0, 1, 7, 0, 1);
        applyStimulus(0, 1, 2'b01, 0, 0, 0, 0, 1); settle(); checkOutput("step zero hold", int'(recon_out), 7);

        // Window: ups at 0,3,6,9,15 and downs at 2,5,8
        applyStimulus(1, 0, 2'b00, 1, 0, 0, 0, 1);
        for (int i = 0; i < WINDOW; i++) begin
            sp = 2'b00;
            if (i == 0 || i == 3 || i == 6 || i == 9 || i == 15) sp = 2'b01;
            if (i == 2 || i == 5 || i == 8) sp = 2'b10;
            applyStimulus(0, 1, sp, 1, 0, 0, 0, 1);
        end
        settle();
        checkOutput("window valid", int'(win_valid), 1);
        checkOutput("window up", int'(win_up), 5);
        checkOutput("window down", int'(win_down), 3);
        applyStimulus(0, 1, 2'b00, 1, 0, 0, 0, 1); settle();
        checkOutput("window valid drop", int'(win_valid), 0);

        // Backpressure over two windows
        applyStimulus(1, 0, 2'b00, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * WINDOW; i++) begin
            sp = 2'b00;
            if (i < 4) sp = 2'b01;
            if (i == 16 || i == 17) sp = 2'b10;
            applyStimulus(0, 1, sp, 1, 0, 0, 0, 0);
        end
        settle();
        checkOutput("bp valid held", int'(win_valid), 1);
        checkOutput("bp first up", int'(win_up), 4);
        checkOutput("bp first down", int'(win_down), 0);
        checkOutput("bp overrun", int'(overrun), 1);
        applyStimulus(0, 0, 2'b00, 1, 0, 0, 0, 1); settle();
        checkOutput("bp transfer", int'(win_valid), 0);
        checkOutput("bp overrun kept", int'(overrun), 1);
        applyStimulus(0, 0, 2'b00, 1, 0, 0, 1, 0); settle();
        checkOutput("bp overrun cleared", int'(overrun), 0);

        // Conflict and enable gating
        applyStimulus(1, 0, 2'b00, 2, 0, 0, 0, 0);
        applyStimulus(0, 1, 2'b00, 2, 1, 9, 0, 0);
        applyStimulus(0, 1, 2'b11, 2, 0, 0, 0, 0); settle();
        checkOutput("conflict recon", int'(recon_out), 9);
        checkOutput("conflict flag", int'(conflict), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2'b01, 2, 0, 0, 0, 0);
        settle();
        checkOutput("en0 recon", int'(recon_out), 9);
        for (int i = 0; i < WINDOW - 3; i++) applyStimulus(0, 1, 2'b00, 2, 0, 0, 0, 0);
        settle();
        checkOutput("en0 not yet", int'(win_valid), 0);
        applyStimulus(0, 1, 2'b00, 2, 0, 0, 0, 0); settle();
        checkOutput("en0 complete", int'(win_valid), 1);
        checkOutput("conflict no up", int'(win_up), 0);
        checkOutput("conflict no down", int'(win_down), 0);

        // Mid-window reset
        applyStimulus(1, 0, 2'b00, 1, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            sp = (i == 1 || i == 5) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b00);
            applyStimulus(0, 1, sp, 1, 0, 0, 0, 1);
        end
        applyStimulus(1, 0, 2'b00, 1, 0, 0, 0, 1); settle();
        checkAllZero("midreset");
        for (int i = 0; i < WINDOW - 1; i++)
            applyStimulus(0, 1, (i == 1 || i == 10) ? 2'b01 : 2'b00, 1, 0, 0, 0, 1);
        settle();
        checkOutput("post reset early", int'(win_valid), 0);
        applyStimulus(0, 1, 2'b00, 1, 0, 0, 0, 1); settle();
        checkOutput("post reset valid", int'(win_valid), 1);
        checkOutput("post reset up", int'(win_up), 2);
        checkOutput("post reset down", int'(win_down), 0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 4) != 0),
                          2'($urandom_range(0, 3)),
                          DATA_W'($urandom_range(0, MAXV)),
                          ($urandom_range(0, 19) == 0),
                          DATA_W'($urandom_range(0, MAXV)),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 2) == 0));
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
